// File: rtl/snake_direction_queue_pkg.sv
// Shared encodings for the snake direction queue: direction codes, PS/2 set-2 key bytes,
// and the key decoder states.
package snake_direction_queue_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    localparam logic [7:0] KEY_W     = 8'h1D;
    localparam logic [7:0] KEY_S     = 8'h1B;
    localparam logic [7:0] KEY_A     = 8'h1C;
    localparam logic [7:0] KEY_D     = 8'h23;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_ESC   = 8'h76;
    localparam logic [7:0] KEY_EXT   = 8'hE0;
    localparam logic [7:0] KEY_BRK   = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } dec_state_t;

    // Opposite direction: flipping bit 0 swaps UP/DOWN and LEFT/RIGHT.
    function automatic logic [1:0] reverse_dir(input logic [1:0] d);
        return {d[1], ~d[0]};
    endfunction

endpackage

// File: rtl/snake_direction_queue_dir_fifo.sv
// Register FIFO of 2-bit turns. Exposes both the head (next to apply) and the newest entry
// (reference for legality); push is honoured when full if a pop happens in the same cycle.
module snake_dir_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [1:0]               push_data,
    output logic [1:0]               head,
    output logic [1:0]               newest,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [1:0]    mem_reg [DEPTH];
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [PW-1:0] newest_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty      = (count_reg == '0);
    assign full       = (count_reg == CW'(DEPTH));
    assign do_pop     = pop && !empty;
    assign do_push    = push && (!full || do_pop);
    assign newest_ptr = wr_ptr_reg - PW'(1);
    assign head       = mem_reg[rd_ptr_reg];
    assign newest     = mem_reg[newest_ptr];
    assign count      = count_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    mem_reg[gi] <= 2'b00;
                end else if (!clear && do_push && (wr_ptr_reg == PW'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/snake_direction_queue.sv
// Decodes PS/2 set-2 key bytes into turn requests and ESC, rejects null/reverse turns,
// and queues legal turns for the game core to consume one per movement tick.
module snake_direction_queue
    import snake_direction_queue_pkg::*;
#(
    parameter int         QUEUE_DEPTH = 4,
    parameter logic [1:0] INIT_DIR    = 2'b11
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          key_valid,
    input  logic [7:0]                    key_code,
    input  logic                          tick,
    input  logic                          restart,
    output logic [1:0]                    direction,
    output logic                          esc_pulse,
    output logic [$clog2(QUEUE_DEPTH):0]  queue_count,
    output logic                          overflow
);
    dec_state_t state_reg;
    logic [1:0] direction_reg;
    logic       esc_reg;
    logic       overflow_reg;

    logic       req_valid;
    logic [1:0] req_dir;
    logic [1:0] ref_dir;
    logic       legal;
    logic       do_pop;

    logic [1:0] fifo_head;
    logic [1:0] fifo_newest;
    logic       fifo_full;
    logic       fifo_empty;

    always_comb begin
        req_valid = 1'b0;
        req_dir   = DIR_UP;
        if (key_valid) begin
            if (state_reg == ST_IDLE) begin
                case (key_code)
                    KEY_W:   begin req_valid = 1'b1; req_dir = DIR_UP;    end
                    KEY_S:   begin req_valid = 1'b1; req_dir = DIR_DOWN;  end
                    KEY_A:   begin req_valid = 1'b1; req_dir = DIR_LEFT;  end
                    KEY_D:   begin req_valid = 1'b1; req_dir = DIR_RIGHT; end
                    default: ;
                endcase
            end else if (state_reg == ST_EXT) begin
                case (key_code)
                    KEY_UP:    begin req_valid = 1'b1; req_dir = DIR_UP;    end
                    KEY_DOWN:  begin req_valid = 1'b1; req_dir = DIR_DOWN;  end
                    KEY_LEFT:  begin req_valid = 1'b1; req_dir = DIR_LEFT;  end
                    KEY_RIGHT: begin req_valid = 1'b1; req_dir = DIR_RIGHT; end
                    default:   ;
                endcase
            end
        end
    end

    // Legality is judged against the last turn the snake will have taken, not the current one.
    assign ref_dir = fifo_empty ? direction_reg : fifo_newest;
    assign legal   = req_valid && (req_dir != ref_dir) && (req_dir != reverse_dir(ref_dir));
    assign do_pop  = tick && !fifo_empty && !restart;

    snake_dir_fifo #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .clear     (restart),
        .push      (legal),
        .pop       (do_pop),
        .push_data (req_dir),
        .head      (fifo_head),
        .newest    (fifo_newest),
        .count     (queue_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            esc_reg   <= 1'b0;
        end else if (restart) begin
            state_reg <= ST_IDLE;
            esc_reg   <= 1'b0;
        end else begin
            esc_reg <= 1'b0;
            if (key_valid) begin
                case (state_reg)
                    ST_IDLE: begin
                        if (key_code == KEY_EXT)      state_reg <= ST_EXT;
                        else if (key_code == KEY_BRK) state_reg <= ST_BRK;
                        else                          state_reg <= ST_IDLE;
                        if (key_code == KEY_ESC)      esc_reg   <= 1'b1;
                    end
                    ST_EXT: begin
                        if (key_code == KEY_BRK) state_reg <= ST_EXT_BRK;
                        else                     state_reg <= ST_IDLE;
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            direction_reg <= INIT_DIR;
            overflow_reg  <= 1'b0;
        end else if (restart) begin
            direction_reg <= INIT_DIR;
            overflow_reg  <= 1'b0;
        end else begin
            if (do_pop) direction_reg <= fifo_head;
            if (legal && fifo_full && !do_pop) overflow_reg <= 1'b1;
        end
    end

    assign direction = direction_reg;
    assign esc_pulse = esc_reg;
    assign overflow  = overflow_reg;

endmodule
